// File: rtl/seven_seg_bcd_display.sv
// Multi-digit seven-segment driver: binary value in, sequential double-dabble
// to BCD, then blanked/overflow-dashed active-low segments with optional blink.
module seven_seg_bcd_display #(
    parameter int VALUE_W    = 16,
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_W    = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_ready,
    input  logic                    i_blink,
    output logic [7*NUM_DIGITS-1:0] o_seven,
    output logic                    o_overflow
);

    localparam int CONV_DIGITS = (VALUE_W + 2) / 3 + 1;
    localparam int BCD_W       = 4 * CONV_DIGITS;
    localparam int EXT_DIGITS  = (CONV_DIGITS > NUM_DIGITS) ? CONV_DIGITS : NUM_DIGITS;
    localparam int CNT_W       = $clog2(VALUE_W);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VALUE_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    localparam logic [6:0] DARK = 7'b1111111;
    localparam logic [6:0] DASH = 7'b0111111;

    logic [1:0]                state;
    logic [VALUE_W-1:0]        bin;
    logic [BCD_W-1:0]          bcd;
    logic [BCD_W-1:0]          bcd_adj;
    logic [CNT_W-1:0]          cnt;
    logic [4*EXT_DIGITS-1:0]   ext;
    logic                      seen;
    logic [7*NUM_DIGITS-1:0]   seg_d;
    logic [7*NUM_DIGITS-1:0]   seg_q;
    logic                      ovf_d;
    logic                      ovf_q;
    logic [BLINK_W-1:0]        presc;
    logic                      phase;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 7'b1000000;
            4'd1:    digit_code = 7'b1111001;
            4'd2:    digit_code = 7'b0100100;
            4'd3:    digit_code = 7'b0110000;
            4'd4:    digit_code = 7'b0011001;
            4'd5:    digit_code = 7'b0010010;
            4'd6:    digit_code = 7'b0000010;
            4'd7:    digit_code = 7'b1011000;
            4'd8:    digit_code = 7'b0000000;
            4'd9:    digit_code = 7'b0010000;
            default: digit_code = DARK;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < CONV_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digits above the most significant nonzero one stay dark; digit 0 always shows.
    always_comb begin
        ext              = '0;
        ext[BCD_W-1:0]   = bcd;
        ovf_d            = 1'b0;
        seen             = 1'b0;
        seg_d            = '1;
        for (int i = NUM_DIGITS; i < EXT_DIGITS; i++)
            ovf_d = ovf_d | (|ext[4*i +: 4]);
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (ext[4*k +: 4] != 4'd0 || k == 0)
                seen = 1'b1;
            if (ovf_d)
                seg_d[7*k +: 7] = DASH;
            else if (seen)
                seg_d[7*k +: 7] = digit_code(ext[4*k +: 4]);
            else
                seg_d[7*k +: 7] = DARK;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            seg_q <= '1;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        bin   <= i_value;
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[BCD_W-2:0], bin[VALUE_W-1]};
                    bin <= {bin[VALUE_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_SHIFT)
                        state <= LOAD;
                end
                LOAD: begin
                    seg_q <= seg_d;
                    ovf_q <= ovf_d;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc <= '0;
            phase <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            if (&presc)
                phase <= ~phase;
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_seven    = seg_q | {(7*NUM_DIGITS){i_blink & phase}};
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_seven_seg_bcd_display.sv
// Directed bench for seven_seg_bcd_display: blanking, overflow, handshake,
// mid-conversion reset and blink masking with a short prescaler.
module tb_seven_seg_bcd_display;

    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001;
    localparam logic [6:0] C5 = 7'b0010010;
    localparam logic [6:0] C6 = 7'b0000010;
    localparam logic [6:0] C7 = 7'b1011000;
    localparam logic [6:0] C8 = 7'b0000000;
    localparam logic [6:0] C9 = 7'b0010000;
    localparam logic [6:0] DK = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    localparam logic [27:0] IMG_305   = {DK, C3, C0, C5};
    localparam logic [27:0] IMG_0     = {DK, DK, DK, C0};
    localparam logic [27:0] IMG_9999  = {C9, C9, C9, C9};
    localparam logic [27:0] IMG_DASH  = {DS, DS, DS, DS};
    localparam logic [27:0] IMG_1234  = {C1, C2, C3, C4};
    localparam logic [27:0] IMG_5678  = {C5, C6, C7, C8};
    localparam logic [27:0] IMG_42    = {DK, DK, C4, C2};
    localparam logic [27:0] IMG_DARK  = 28'hFFFFFFF;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [15:0] value;
    logic        ready;
    logic        blink;
    logic [27:0] seven;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    seven_seg_bcd_display #(
        .VALUE_W    (16),
        .NUM_DIGITS (4),
        .BLINK_W    (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .i_value    (value),
        .o_ready    (ready),
        .i_blink    (blink),
        .o_seven    (seven),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the blink phase model is derived from this.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready) check({tag, "_timeout"}, 32'(ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic [15:0] v,
                        input logic [27:0] img, input logic ovf);
        int n;
        wait_ready({tag, "_pre"}, n);
        valid = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_ready(tag, n);
        check({tag, "_lat"}, 32'(n), 32'd17);
        check({tag, "_seg"}, 32'(seven), 32'(img));
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        valid = 1'b0;
        value = '0;
        blink = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_seg", 32'(seven), 32'(IMG_DARK));
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rdy", 32'(ready), 32'd1);

        send("v305", 16'd305, IMG_305, 1'b0);
        send("v0", 16'd0, IMG_0, 1'b0);
        send("v9999", 16'd9999, IMG_9999, 1'b0);
        send("v10000", 16'd10000, IMG_DASH, 1'b1);
        send("v65535", 16'd65535, IMG_DASH, 1'b1);

        // Overlapping request: second value waits until the FSM is idle again.
        valid = 1'b1;
        value = 16'd1234;
        @(posedge clk);
        #1;
        value = 16'd5678;
        check("hs_busy", 32'(ready), 32'd0);
        wait_ready("hs1", n);
        check("hs1_lat", 32'(n), 32'd17);
        check("hs1_seg", 32'(seven), 32'(IMG_1234));
        check("hs1_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        check("hs2_acc", 32'(ready), 32'd0);
        valid = 1'b0;
        wait_ready("hs2", n);
        check("hs2_lat", 32'(n), 32'd17);
        check("hs2_seg", 32'(seven), 32'(IMG_5678));

        send("pre_ovf", 16'd65535, IMG_DASH, 1'b1);
        valid = 1'b1;
        value = 16'd305;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_seg", 32'(seven), 32'(IMG_DARK));
        check("mid_ovf", 32'(overflow), 32'd0);
        check("mid_rdy", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("post_seg", 32'(seven), 32'(IMG_DARK));
        check("post_ovf", 32'(overflow), 32'd0);
        check("post_rdy", 32'(ready), 32'd1);

        send("v42", 16'd42, IMG_42, 1'b0);
        blink = 1'b1;
        #1;
        check("blk_now", 32'(seven),
              32'((((cyc / 16) % 2) == 1) ? IMG_DARK : IMG_42));
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("blk_%0d", i), 32'(seven),
                  32'((((cyc / 16) % 2) == 1) ? IMG_DARK : IMG_42));
        end
        check("blk_ovf", 32'(overflow), 32'd0);
        n = 0;
        while (((cyc / 16) % 2) != 1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("blk_hi", 32'(seven), 32'(IMG_DARK));
        blink = 1'b0;
        #1;
        check("blk_off", 32'(seven), 32'(IMG_42));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
